// File: rtl/des_byte_packer.sv
// Packs a byte stream into 64-bit DES plaintext blocks through a one-deep output
// holding register. Defining DES_PKCS_PAD_EN turns on PKCS#5-style padding of final blocks.
module des_byte_packer #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [63:0] blk_data,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        blk_last,
  output logic [3:0]  blk_bytes
);

  typedef enum logic [1:0] {FILL, HOLD, PAD} state_t;

  localparam logic [63:0] PAD_BLK = {8{8'h08}};

  state_t      state_q, state_d;
  logic        run_q;
  logic [2:0]  cnt_q, cnt_d;
  logic [63:0] asm_p0, asm_d;
  logic        pend_last_q, pend_last_d;
  logic [3:0]  pend_bytes_q, pend_bytes_d;
  logic        pend_pad_q, pend_pad_d;
  logic [63:0] data_p1, data_d;
  logic        vld_p1, vld_d;
  logic        last_p1, last_d;
  logic [3:0]  bytes_p1, bytes_d;

  logic        accept, can_load, done;
  logic [3:0]  n_used;
  logic [63:0] lane_blk, fin_data;
  logic        fin_last, fin_pad;
  logic [3:0]  fin_bytes;

  function automatic logic [63:0] put_lane(input logic [63:0] blk, input logic [2:0] lane,
                                           input logic [7:0] b);
    logic [63:0] r;
    int          base;
    r    = blk;
    base = (MSB_FIRST != 0) ? 56 - 8 * int'(lane) : 8 * int'(lane);
    r[base +: 8] = b;
    return r;
  endfunction

`ifdef DES_PKCS_PAD_EN
  function automatic logic [63:0] pad_fill(input logic [63:0] blk, input logic [3:0] n);
    logic [63:0] r;
    r = blk;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(n)) r = put_lane(r, 3'(i), 8'(4'd8 - n));
    end
    return r;
  endfunction
`endif

  assign in_ready  = run_q && (state_q == FILL);
  assign blk_data  = data_p1;
  assign blk_valid = vld_p1;
  assign blk_last  = last_p1;
  assign blk_bytes = bytes_p1;

  assign accept   = in_valid && in_ready;
  assign can_load = !vld_p1 || blk_ready;
  assign done     = accept && ((cnt_q == 3'd7) || in_last);
  assign n_used   = {1'b0, cnt_q} + 4'd1;
  assign lane_blk = put_lane(asm_p0, cnt_q, in_data);

`ifdef DES_PKCS_PAD_EN
  // A full final block is followed by a whole block of padding, so it is not itself last.
  assign fin_data  = (in_last && (cnt_q != 3'd7)) ? pad_fill(lane_blk, n_used) : lane_blk;
  assign fin_bytes = 4'd8;
  assign fin_last  = in_last && (cnt_q != 3'd7);
  assign fin_pad   = in_last && (cnt_q == 3'd7);
`else
  assign fin_data  = lane_blk;
  assign fin_bytes = n_used;
  assign fin_last  = in_last;
  assign fin_pad   = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    asm_d        = asm_p0;
    pend_last_d  = pend_last_q;
    pend_bytes_d = pend_bytes_q;
    pend_pad_d   = pend_pad_q;
    data_d       = data_p1;
    last_d       = last_p1;
    bytes_d      = bytes_p1;
    vld_d        = vld_p1 && !blk_ready;
    unique case (state_q)
      FILL: begin
        if (done) begin
          cnt_d = 3'd0;
          if (can_load) begin
            data_d  = fin_data;
            last_d  = fin_last;
            bytes_d = fin_bytes;
            vld_d   = 1'b1;
            asm_d   = '0;
            state_d = fin_pad ? PAD : FILL;
          end else begin
            asm_d        = fin_data;
            pend_last_d  = fin_last;
            pend_bytes_d = fin_bytes;
            pend_pad_d   = fin_pad;
            state_d      = HOLD;
          end
        end else if (accept) begin
          asm_d = lane_blk;
          cnt_d = cnt_q + 3'd1;
        end
      end
      HOLD: begin
        if (can_load) begin
          data_d  = asm_p0;
          last_d  = pend_last_q;
          bytes_d = pend_bytes_q;
          vld_d   = 1'b1;
          asm_d   = '0;
          state_d = pend_pad_q ? PAD : FILL;
        end
      end
      PAD: begin
        if (can_load) begin
          data_d  = PAD_BLK;
          last_d  = 1'b1;
          bytes_d = 4'd8;
          vld_d   = 1'b1;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Stage p0: byte assembly and control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      run_q        <= 1'b0;
      cnt_q        <= 3'd0;
      asm_p0       <= '0;
      pend_last_q  <= 1'b0;
      pend_bytes_q <= 4'd0;
      pend_pad_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= 1'b1;
      cnt_q        <= cnt_d;
      asm_p0       <= asm_d;
      pend_last_q  <= pend_last_d;
      pend_bytes_q <= pend_bytes_d;
      pend_pad_q   <= pend_pad_d;
    end
  end

  // Stage p1: output holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_p1  <= '0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
      bytes_p1 <= 4'd0;
    end else begin
      data_p1  <= data_d;
      vld_p1   <= vld_d;
      last_p1  <= last_d;
      bytes_p1 <= bytes_d;
    end
  end

endmodule

// File: tb/tb_des_byte_packer.sv
// Bench for des_byte_packer: directed vector table, multi-cycle sequences and a
// randomized run, all scored against a queue-based block model.
module tb_des_byte_packer;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_last, blk_ready;
  logic [7:0]  in_data;
  logic        in_ready_m, blk_valid_m, blk_last_m;
  logic [63:0] blk_data_m;
  logic [3:0]  blk_bytes_m;
  logic        in_ready_l, blk_valid_l, blk_last_l;
  logic [63:0] blk_data_l;
  logic [3:0]  blk_bytes_l;

  always #5 clk = ~clk;

`ifdef DES_PKCS_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  des_byte_packer #(.MSB_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_m), .blk_data(blk_data_m), .blk_valid(blk_valid_m),
    .blk_ready(blk_ready), .blk_last(blk_last_m), .blk_bytes(blk_bytes_m));

  des_byte_packer #(.MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready_l), .blk_data(blk_data_l), .blk_valid(blk_valid_l),
    .blk_ready(blk_ready), .blk_last(blk_last_l), .blk_bytes(blk_bytes_l));

  typedef struct {
    logic [63:0] msb;
    logic [63:0] lsb;
    logic        last;
    logic [3:0]  bytes;
  } blk_t;

  typedef struct {
    int          n;
    logic [7:0]  b0;
    logic [7:0]  step;
    logic [63:0] exp;
    logic        last;
    logic [3:0]  bytes;
    logic        rdy;
  } vec_t;

  blk_t       expq[$];
  logic [7:0] cur[$];
  int         tests = 0;
  int         fails = 0;
  bit         acc_seen;
  bit         prev_hold;
  blk_t       prev_blk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference: a block is the accepted bytes in arrival order, completed at 8 bytes or last.
  task automatic emit(input bit last);
    int         n;
    blk_t       b;
    logic [7:0] v;
    bit         padded;
    n      = cur.size();
    padded = PAD_EN && last && (n < 8);
    b.msb  = '0;
    b.lsb  = '0;
    for (int i = 0; i < 8; i++) begin
      v = (i < n) ? cur[i] : (padded ? 8'(8 - n) : 8'h00);
      b.msb = b.msb | (64'(v) << (8 * (7 - i)));
      b.lsb = b.lsb | (64'(v) << (8 * i));
    end
    b.bytes = PAD_EN ? 4'd8 : 4'(n);
    b.last  = last && !(PAD_EN && n == 8);
    expq.push_back(b);
    if (PAD_EN && last && n == 8) begin
      b.msb   = {8{8'h08}};
      b.lsb   = {8{8'h08}};
      b.last  = 1'b1;
      b.bytes = 4'd8;
      expq.push_back(b);
    end
    cur.delete();
  endtask

  task automatic mon();
    blk_t e;
    acc_seen = 1'b0;
    if (!rst_n) begin
      expq.delete();
      cur.delete();
      prev_hold = 1'b0;
      return;
    end
    if (prev_hold) begin
      chk("stall_valid", 64'(blk_valid_m), 64'd1);
      chk("stall_data", blk_data_m, prev_blk.msb);
      chk("stall_last", 64'(blk_last_m), 64'(prev_blk.last));
      chk("stall_bytes", 64'(blk_bytes_m), 64'(prev_blk.bytes));
    end
    chk("ready_match", 64'(in_ready_l), 64'(in_ready_m));
    if (blk_valid_m && blk_ready) begin
      if (expq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_block: got %h required no block", blk_data_m);
      end else begin
        e = expq.pop_front();
        chk("blk_msb", blk_data_m, e.msb);
        chk("blk_lsb", blk_data_l, e.lsb);
        chk("blk_last", 64'(blk_last_m), 64'(e.last));
        chk("blk_bytes", 64'(blk_bytes_m), 64'(e.bytes));
        chk("lsb_valid", 64'(blk_valid_l), 64'd1);
      end
    end
    if (in_valid && in_ready_m) begin
      acc_seen = 1'b1;
      cur.push_back(in_data);
      if (cur.size() == 8 || in_last) emit(in_last);
    end
    prev_hold      = blk_valid_m && !blk_ready;
    prev_blk.msb   = blk_data_m;
    prev_blk.lsb   = blk_data_l;
    prev_blk.last  = blk_last_m;
    prev_blk.bytes = blk_bytes_m;
  endtask

  task automatic cyc();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit l, output int stalls);
    bit got;
    got      = 1'b0;
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 100 && !got; k++) begin
      cyc();
      if (acc_seen) got = 1'b1;
      else stalls++;
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got no accept required accept of %h", d);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    vec_t       tbl[4];
    int         st, tot;
    logic [7:0] bv;

`ifdef DES_PKCS_PAD_EN
    tbl[0] = '{8, 8'h01, 8'h01, 64'h0102030405060708, 1'b0, 4'd8, 1'b0};
    tbl[1] = '{3, 8'hAA, 8'h11, 64'hAABBCC0505050505, 1'b1, 4'd8, 1'b1};
    tbl[2] = '{1, 8'h5A, 8'h01, 64'h5A07070707070707, 1'b1, 4'd8, 1'b1};
    tbl[3] = '{7, 8'h10, 8'h01, 64'h1011121314151601, 1'b1, 4'd8, 1'b1};
`else
    tbl[0] = '{8, 8'h01, 8'h01, 64'h0102030405060708, 1'b1, 4'd8, 1'b1};
    tbl[1] = '{3, 8'hAA, 8'h11, 64'hAABBCC0000000000, 1'b1, 4'd3, 1'b1};
    tbl[2] = '{1, 8'h5A, 8'h01, 64'h5A00000000000000, 1'b1, 4'd1, 1'b1};
    tbl[3] = '{7, 8'h10, 8'h01, 64'h1011121314151600, 1'b1, 4'd7, 1'b1};
`endif

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_data   = 8'h00;
    blk_ready = 1'b0;
    prev_hold = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", 64'(blk_valid_m), 64'd0);
    chk("rst_data", blk_data_m, 64'd0);
    chk("rst_last", 64'(blk_last_m), 64'd0);
    chk("rst_bytes", 64'(blk_bytes_m), 64'd0);
    chk("rst_ready", 64'(in_ready_m), 64'd0);
    rst_n = 1'b1;
    chk("rel_ready_low", 64'(in_ready_m), 64'd0);
    cyc();
    chk("rel_ready_high", 64'(in_ready_m), 64'd1);

    // Single-message vectors, one cycle after the final byte is accepted
    blk_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < tbl[i].n; j++) begin
        bv = tbl[i].b0 + 8'(j) * tbl[i].step;
        send(bv, j == tbl[i].n - 1, st);
      end
      chk("vec_valid", 64'(blk_valid_m), 64'd1);
      chk("vec_data", blk_data_m, tbl[i].exp);
      chk("vec_last", 64'(blk_last_m), 64'(tbl[i].last));
      chk("vec_bytes", 64'(blk_bytes_m), 64'(tbl[i].bytes));
      chk("vec_ready", 64'(in_ready_m), 64'(tbl[i].rdy));
      for (int k = 0; k < 4; k++) cyc();
    end

    // Continuous 16-byte stream: no stalls, second block right behind the first
    tot = 0;
    for (int j = 0; j < 16; j++) begin
      send(8'(j), 1'b0, st);
      tot += st;
    end
    chk("stream_stalls", 64'(tot), 64'd0);
    chk("stream_blk2", blk_data_m, 64'h08090A0B0C0D0E0F);
    for (int k = 0; k < 3; k++) cyc();

    // Consumer stalled: second block waits in HOLD, then both drain in order
    blk_ready = 1'b0;
    tot = 0;
    for (int j = 0; j < 16; j++) begin
      send(8'h30 + 8'(j), 1'b0, st);
      tot += st;
    end
    chk("hold_stalls", 64'(tot), 64'd0);
    chk("hold_ready", 64'(in_ready_m), 64'd0);
    chk("hold_blk1", blk_data_m, 64'h3031323334353637);
    cyc();
    cyc();
    chk("hold_ready2", 64'(in_ready_m), 64'd0);
    blk_ready = 1'b1;
    cyc();
    chk("drain_blk2", blk_data_m, 64'h38393A3B3C3D3E3F);
    chk("drain_ready", 64'(in_ready_m), 64'd1);
    cyc();
    chk("drain_empty", 64'(blk_valid_m), 64'd0);
    chk("drain_queue", 64'(expq.size()), 64'd0);

    // Reset mid-block with a full holding register
    blk_ready = 1'b0;
    for (int j = 0; j < 13; j++) send(8'h40 + 8'(j), 1'b0, st);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(blk_valid_m), 64'd0);
    chk("mid_rst_data", blk_data_m, 64'd0);
    chk("mid_rst_ready", 64'(in_ready_m), 64'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    chk("mid_rel_ready", 64'(in_ready_m), 64'd0);
    blk_ready = 1'b1;
    for (int j = 0; j < 8; j++) send(8'h60 + 8'(j), 1'b0, st);
    chk("fresh_valid", 64'(blk_valid_m), 64'd1);
    chk("fresh_data", blk_data_m, 64'h6061626364656667);
    chk("fresh_lsb", blk_data_l, 64'h6766656463626160);
    chk("fresh_last", 64'(blk_last_m), 64'd0);
    for (int k = 0; k < 3; k++) cyc();

    // Randomized traffic with random back-pressure
    for (int k = 0; k < 600; k++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      blk_ready = ($urandom_range(0, 9) < 6);
      cyc();
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b1;
    send(8'hE7, 1'b1, st);
    for (int k = 0; k < 20; k++) cyc();
    chk("final_queue", 64'(expq.size()), 64'd0);
    chk("final_valid", 64'(blk_valid_m), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
